// File: rtl/audio_sector_scheduler.sv
// ADPCM sector scheduler: queues sector descriptors from the CDIC, launches them back-to-back
// on the sector player, counts output samples to detect sector end and returns buffer tags.
package audio_sector_pkg;
  localparam logic [1:0] k4Bps = 2'b00;
  localparam logic [1:0] k8Bps = 2'b01;

  typedef struct packed {
    logic       emphasis;
    logic       reserved;
    logic [1:0] bps;
    logic [1:0] rate;
    logic [1:0] chan;
  } header_coding_s;
endpackage

module audio_sector_scheduler
  import audio_sector_pkg::*;
#(
  parameter int QUEUE_DEPTH  = 4,
  parameter int TAG_W        = 2,
  parameter int SAMPLES_4BPS = 4032,
  parameter int SAMPLES_8BPS = 2016
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           push_valid,
  output logic                           push_ready,
  input  logic [12:0]                    push_addr,
  input  header_coding_s                 push_coding,
  input  logic [TAG_W-1:0]               push_tag,
  input  logic                           stop,
  output logic                           start_playback,
  output logic [12:0]                    playback_addr,
  output header_coding_s                 playback_coding,
  input  logic                           sample_strobe,
  output logic                           release_valid,
  output logic [TAG_W-1:0]               release_tag,
  output logic                           underrun,
  output logic                           busy,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_level
);

  localparam int PTR_W   = $clog2(QUEUE_DEPTH);
  localparam int MAX_SMP = (SAMPLES_4BPS > SAMPLES_8BPS) ? SAMPLES_4BPS : SAMPLES_8BPS;
  localparam int CNT_W   = $clog2(MAX_SMP + 1);

  localparam logic [CNT_W-1:0] LOAD_4BPS = CNT_W'(SAMPLES_4BPS);
  localparam logic [CNT_W-1:0] LOAD_8BPS = CNT_W'(SAMPLES_8BPS);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LAUNCH  = 3'd1;
  localparam logic [2:0] S_PLAYING = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_FLUSH   = 3'd4;

  logic [2:0]           state, state_nxt;
  logic                 stop_pending;
  logic                 clr_stop;
  logic [PTR_W:0]       wr_ptr, rd_ptr;
  logic [PTR_W:0]       level;
  logic                 full, empty;
  logic                 push_fire, pop;
  logic [PTR_W-1:0]     wr_idx, rd_idx;
  logic [CNT_W-1:0]     sample_cnt;
  logic [12:0]          cur_addr;
  header_coding_s       cur_coding;
  logic [TAG_W-1:0]     cur_tag;

  logic [12:0]          addr_mem   [QUEUE_DEPTH];
  header_coding_s       coding_mem [QUEUE_DEPTH];
  logic [TAG_W-1:0]     tag_mem    [QUEUE_DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level  = wr_ptr - rd_ptr;
  assign full   = (level == (PTR_W+1)'(QUEUE_DEPTH));
  assign empty  = (level == '0);
  assign wr_idx = wr_ptr[PTR_W-1:0];
  assign rd_idx = rd_ptr[PTR_W-1:0];

  assign push_ready = !full && !stop_pending;
  assign push_fire  = push_valid && push_ready;
  assign pop        = (state == S_LAUNCH) || (state == S_FLUSH);

  always_comb begin
    state_nxt = state;
    clr_stop  = 1'b0;
    case (state)
      S_IDLE: begin
        if (stop_pending && !empty) begin
          state_nxt = S_FLUSH;
        end else if (stop_pending) begin
          clr_stop = 1'b1;
        end else if (!empty) begin
          state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: state_nxt = S_PLAYING;
      S_PLAYING: begin
        if (sample_strobe && (sample_cnt == CNT_W'(1))) begin
          state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (stop_pending) begin
          if (!empty) begin
            state_nxt = S_FLUSH;
          end else begin
            clr_stop  = 1'b1;
            state_nxt = S_IDLE;
          end
        end else if (!empty) begin
          state_nxt = S_LAUNCH;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (level == (PTR_W+1)'(1)) begin
          clr_stop  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      stop_pending <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      sample_cnt   <= '0;
      cur_addr     <= '0;
      cur_coding   <= '0;
      cur_tag      <= '0;
    end else begin
      state <= state_nxt;
      // A fresh stop wins over a clear landing in the same cycle.
      if (stop) begin
        stop_pending <= 1'b1;
      end else if (clr_stop) begin
        stop_pending <= 1'b0;
      end
      if (push_fire) begin
        wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
      if (state == S_LAUNCH) begin
        cur_addr   <= addr_mem[rd_idx];
        cur_coding <= coding_mem[rd_idx];
        cur_tag    <= tag_mem[rd_idx];
        sample_cnt <= (coding_mem[rd_idx].bps == k8Bps) ? LOAD_8BPS : LOAD_4BPS;
      end else if ((state == S_PLAYING) && sample_strobe && (sample_cnt != '0)) begin
        sample_cnt <= sample_cnt - CNT_W'(1);
      end
    end
  end

  // Descriptor storage holds no reset: entries are only read behind a valid pointer.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      addr_mem[wr_idx]   <= push_addr;
      coding_mem[wr_idx] <= push_coding;
      tag_mem[wr_idx]    <= push_tag;
    end
  end

  // The launched descriptor is visible on the playback bus during the launch pulse itself.
  assign start_playback  = (state == S_LAUNCH);
  assign playback_addr   = (state == S_LAUNCH) ? addr_mem[rd_idx]   : cur_addr;
  assign playback_coding = (state == S_LAUNCH) ? coding_mem[rd_idx] : cur_coding;
  assign release_valid   = (state == S_RELEASE) || (state == S_FLUSH);
  assign release_tag     = (state == S_FLUSH) ? tag_mem[rd_idx] : cur_tag;
  assign underrun        = (state == S_RELEASE) && !stop_pending && empty;
  assign busy            = (state != S_IDLE);
  assign queue_level     = level;

  a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset_n) !(pop && empty));
  a_no_push_full: assert property (@(posedge clk) disable iff (!reset_n) !(push_fire && full && !pop));

endmodule

// File: tb/tb_audio_sector_scheduler.sv
// Bench for audio_sector_scheduler: directed scenarios plus random traffic, all checked
// every cycle against a queue-based model of the scheduling rules.
module tb_audio_sector_scheduler;
  import audio_sector_pkg::*;

  logic           clk;
  logic           reset_n;
  logic           push_valid;
  logic           push_ready;
  logic [12:0]    push_addr;
  header_coding_s push_coding;
  logic [1:0]     push_tag;
  logic           stop;
  logic           start_playback;
  logic [12:0]    playback_addr;
  header_coding_s playback_coding;
  logic           sample_strobe;
  logic           release_valid;
  logic [1:0]     release_tag;
  logic           underrun;
  logic           busy;
  logic [2:0]     queue_level;

  audio_sector_scheduler dut (
    .clk(clk), .reset_n(reset_n),
    .push_valid(push_valid), .push_ready(push_ready), .push_addr(push_addr),
    .push_coding(push_coding), .push_tag(push_tag), .stop(stop),
    .start_playback(start_playback), .playback_addr(playback_addr),
    .playback_coding(playback_coding), .sample_strobe(sample_strobe),
    .release_valid(release_valid), .release_tag(release_tag), .underrun(underrun),
    .busy(busy), .queue_level(queue_level)
  );

  int errors = 0;
  int checks = 0;
  int strobe_pct = 100;
  int ncyc = 0;

  typedef struct {
    logic [12:0] addr;
    logic [7:0]  coding;
    logic [1:0]  tag;
  } desc_t;

  // Model: pending descriptors, what is playing, samples left, whether a stop is owed.
  desc_t       mq[$];
  int          m_ph;      // 0 waiting, 1 launching, 2 playing, 3 retiring current, 4 flushing
  bit          m_stop;
  int          m_left;
  logic [12:0] m_addr;
  logic [7:0]  m_cod;
  logic [1:0]  m_tag;
  int          acc_n, rel_n;

  int          launch_cyc[$];
  logic [12:0] launch_addr[$];
  int          acc_cyc[$];
  int          rel_cyc[$];
  logic [1:0]  rel_tag[$];
  int          und_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    sample_strobe = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      sample_strobe = ($urandom_range(0, 99) < strobe_pct);
    end
  end

  // Compare process: checks every cycle, logs events, then advances the model.
  initial begin
    desc_t head;
    bit    exp_pr, acc, clr;
    forever begin
      @(negedge clk);
      ncyc++;
      if (!reset_n) begin
        mq.delete();
        m_ph = 0; m_stop = 0; m_left = 0; m_addr = '0; m_cod = '0; m_tag = '0;
        acc_n = 0; rel_n = 0;
        chk("rst_start_playback", start_playback, 0);
        chk("rst_busy", busy, 0);
        chk("rst_queue_level", queue_level, 0);
        chk("rst_release_valid", release_valid, 0);
        chk("rst_release_tag", release_tag, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_playback_addr", playback_addr, 0);
        chk("rst_playback_coding", playback_coding, 0);
        chk("rst_push_ready", push_ready, 1);
      end else begin
        head.addr = '0; head.coding = '0; head.tag = '0;
        if (mq.size() > 0) head = mq[0];
        exp_pr = (mq.size() < 4) && !m_stop;
        chk("push_ready", push_ready, exp_pr);
        chk("queue_level", queue_level, mq.size());
        chk("busy", busy, m_ph != 0);
        chk("start_playback", start_playback, m_ph == 1);
        chk("playback_addr", playback_addr, (m_ph == 1) ? head.addr : m_addr);
        chk("playback_coding", playback_coding, (m_ph == 1) ? head.coding : m_cod);
        chk("release_valid", release_valid, (m_ph == 3) || (m_ph == 4));
        if (m_ph == 3) chk("release_tag", release_tag, m_tag);
        if (m_ph == 4) chk("flush_tag", release_tag, head.tag);
        chk("underrun", underrun, (m_ph == 3) && !m_stop && (mq.size() == 0));

        if (start_playback) begin
          launch_cyc.push_back(ncyc);
          launch_addr.push_back(playback_addr);
        end
        if (release_valid) begin
          rel_cyc.push_back(ncyc);
          rel_tag.push_back(release_tag);
          rel_n++;
        end
        if (underrun) und_cyc.push_back(ncyc);
        acc = push_valid && exp_pr;
        if (acc) begin
          acc_cyc.push_back(ncyc);
          acc_n++;
        end

        clr = 0;
        case (m_ph)
          0: begin
            if (m_stop && mq.size() > 0) m_ph = 4;
            else if (m_stop) clr = 1;
            else if (mq.size() > 0) m_ph = 1;
          end
          1: begin
            head   = mq.pop_front();
            m_addr = head.addr; m_cod = head.coding; m_tag = head.tag;
            m_left = (head.coding[5:4] == 2'b01) ? 2016 : 4032;
            m_ph   = 2;
          end
          2: begin
            if (sample_strobe) begin
              m_left--;
              if (m_left == 0) m_ph = 3;
            end
          end
          3: begin
            if (m_stop) begin
              if (mq.size() > 0) m_ph = 4;
              else begin clr = 1; m_ph = 0; end
            end else if (mq.size() > 0) m_ph = 1;
            else m_ph = 0;
          end
          default: begin
            void'(mq.pop_front());
            if (mq.size() == 0) begin clr = 1; m_ph = 0; end
          end
        endcase
        if (acc) begin
          head.addr = push_addr; head.coding = push_coding; head.tag = push_tag;
          mq.push_back(head);
        end
        if (clr) m_stop = 0;
        if (stop) m_stop = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    launch_cyc.delete(); launch_addr.delete(); acc_cyc.delete();
    rel_cyc.delete(); rel_tag.delete(); und_cyc.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 so consecutive calls push back-to-back.
  task automatic push(input logic [12:0] a, input logic [7:0] c, input logic [1:0] t);
    bit ok = 0;
    int n = 0;
    push_valid = 1'b1; push_addr = a; push_coding = c; push_tag = t;
    while (!ok && n < 20000) begin
      @(negedge clk);
      ok = push_ready;
      n++;
    end
    tick();
    push_valid = 1'b0;
    if (!ok) chk("push_accept_timeout", ok, 1);
  endtask

  task automatic wait_idle(input int limit);
    bit done = 0;
    int n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      done = !busy && (queue_level == 0) && push_ready;
      n++;
    end
    chk("wait_idle_reached", done, 1);
    tick();
  endtask

  task automatic wait_launches(input int cnt, input int limit);
    int n = 0;
    while (launch_cyc.size() < cnt && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("wait_launch_reached", launch_cyc.size() >= cnt, 1);
    tick();
  endtask

  initial begin
    reset_n = 1'b0; push_valid = 1'b0; push_addr = '0; push_coding = '0;
    push_tag = '0; stop = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    tick();

    // T1: single 4bps sector
    clear_logs();
    push(13'h100, 8'h04, 2'd1);
    wait_idle(6000);
    chk("t1_launches", launch_cyc.size(), 1);
    chk("t1_launch_latency", launch_cyc[0] - acc_cyc[0], 2);
    chk("t1_launch_addr", launch_addr[0], 13'h100);
    chk("t1_releases", rel_tag.size(), 1);
    chk("t1_release_tag", rel_tag[0], 1);
    chk("t1_sector_len", rel_cyc[0] - launch_cyc[0], 4033);
    chk("t1_underruns", und_cyc.size(), 1);
    chk("t1_underrun_cycle", und_cyc[0], rel_cyc[0]);

    // T2: three 8bps sectors back-to-back
    clear_logs();
    push(13'h200, 8'h15, 2'd0);
    push(13'h300, 8'h15, 2'd1);
    push(13'h400, 8'h15, 2'd2);
    wait_idle(8000);
    chk("t2_launches", launch_cyc.size(), 3);
    chk("t2_gap01", launch_cyc[1] - launch_cyc[0], 2018);
    chk("t2_gap12", launch_cyc[2] - launch_cyc[1], 2018);
    for (int i = 0; i < 3; i++) chk("t2_release_order", rel_tag[i], i);
    chk("t2_underruns", und_cyc.size(), 1);
    chk("t2_underrun_last", und_cyc[0], rel_cyc[2]);

    // T3: fill the queue while playing, including a push in the launch cycle
    clear_logs();
    push(13'h010, 8'h15, 2'd3);
    push(13'h020, 8'h15, 2'd2);
    push(13'h030, 8'h15, 2'd1);
    push(13'h040, 8'h15, 2'd0);
    push(13'h050, 8'h15, 2'd3);
    @(negedge clk);
    chk("t3_level_full", queue_level, 4);
    chk("t3_ready_full", push_ready, 0);
    chk("t3_push_in_launch", acc_cyc[2], launch_cyc[0]);
    tick();
    wait_idle(12000);
    chk("t3_launches", launch_cyc.size(), 5);
    chk("t3_releases", rel_tag.size(), 5);
    chk("t3_rel0", rel_tag[0], 3);
    chk("t3_rel1", rel_tag[1], 2);
    chk("t3_rel2", rel_tag[2], 1);
    chk("t3_rel3", rel_tag[3], 0);
    chk("t3_rel4", rel_tag[4], 3);
    chk("t3_launch4_addr", launch_addr[4], 13'h050);

    // T4: stop while playing with three queued
    clear_logs();
    push(13'h111, 8'h15, 2'd0);
    push(13'h222, 8'h15, 2'd1);
    push(13'h333, 8'h15, 2'd2);
    push(13'h444, 8'h15, 2'd3);
    wait_launches(1, 100);
    repeat (100) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    @(negedge clk);
    chk("t4_ready_after_stop", push_ready, 0);
    tick();
    wait_idle(4000);
    chk("t4_launches", launch_cyc.size(), 1);
    chk("t4_releases", rel_tag.size(), 4);
    for (int i = 0; i < 4; i++) chk("t4_release_order", rel_tag[i], i);
    for (int i = 0; i < 3; i++) chk("t4_release_back_to_back", rel_cyc[i+1] - rel_cyc[i], 1);
    chk("t4_underruns", und_cyc.size(), 0);
    chk("t4_level", queue_level, 0);

    // T5: stop while idle and empty
    clear_logs();
    stop = 1'b1;
    @(negedge clk);
    chk("t5_ready_same_cycle", push_ready, 1);
    tick();
    stop = 1'b0;
    @(negedge clk);
    chk("t5_ready_low", push_ready, 0);
    tick();
    @(negedge clk);
    chk("t5_ready_back", push_ready, 1);
    chk("t5_no_release", rel_tag.size(), 0);
    tick();
    push(13'h1ABC, 8'h15, 2'd2);
    wait_idle(3000);
    chk("t5_launches", launch_cyc.size(), 1);
    chk("t5_launch_addr", launch_addr[0], 13'h1ABC);
    chk("t5_release_tag", rel_tag[0], 2);

    // T6: reset mid-sector
    clear_logs();
    push(13'h0F0, 8'h05, 2'd3);
    wait_launches(1, 100);
    repeat (500) tick();
    @(negedge clk);
    chk("t6_busy_before", busy, 1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_busy", busy, 0);
    chk("t6_async_addr", playback_addr, 0);
    chk("t6_async_coding", playback_coding, 0);
    chk("t6_async_tag", release_tag, 0);
    chk("t6_async_release", release_valid, 0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    tick();
    chk("t6_no_release", rel_tag.size(), 0);
    clear_logs();
    push(13'h0AA, 8'h05, 2'd0);
    wait_idle(6000);
    chk("t6_launch_latency", launch_cyc[0] - acc_cyc[0], 2);
    chk("t6_full_count", rel_cyc[0] - launch_cyc[0], 4033);
    chk("t6_release_tag", rel_tag[0], 0);

    // Random traffic with back-pressure, occasional stops and sparse strobes
    strobe_pct = 85;
    for (int i = 0; i < 10000; i++) begin
      push_valid  = ($urandom_range(0, 99) < 25);
      push_addr   = 13'($urandom);
      push_coding = {2'($urandom), ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b01, 4'($urandom)};
      push_tag    = 2'($urandom);
      stop        = ($urandom_range(0, 999) == 0);
      tick();
    end
    push_valid = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    strobe_pct = 100;
    wait_idle(8000);
    chk("rand_release_per_accept", rel_n, acc_n);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
